// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage MIPS pipeline.
// Registers EX results, runs word loads/stores over a dm_req/dm_ack
// handshake, back-pressures EX while an access is outstanding and hands a
// one-cycle result (wb_valid) to WB. A watchdog aborts unanswered accesses.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap loads/stores whose
// byte address is not word aligned (no dm_req, bus_err + wb_valid instead).
// Without it the low two address bits are ignored.
module mem_access_stage #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] alu_out,
  input  logic [31:0] write_data,
  input  logic [4:0]  write_reg_addr,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_data,
  output logic        bus_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  // Last watchdog value before the abort fires: the access is aborted on
  // the TIMEOUT-th WAIT edge without an ack.
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] wdog;

  // Context of the outstanding access, replayed to WB on completion.
  logic             pend_reg_write;
  logic [4:0]       pend_reg_addr;
  logic [31:0]      pend_alu;

  logic accept;
  logic is_mem;
  logic misalign;
  logic trap;

  assign ex_ready = (state == IDLE);
  assign accept   = ex_valid & ex_ready;
  assign is_mem   = mem_read | mem_write;
  assign misalign = (alu_out[1:0] != 2'b00);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_mem & misalign;
`else
  // Low address bits are dropped; the access goes to the enclosing word.
  assign trap = is_mem & misalign & 1'b0;
`endif

  // Stage FSM, memory handshake, watchdog and WB result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      wdog           <= '0;
      dm_req         <= 1'b0;
      dm_we          <= 1'b0;
      dm_addr        <= '0;
      dm_wdata       <= '0;
      wb_valid       <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_reg_addr    <= '0;
      wb_data        <= '0;
      bus_err        <= 1'b0;
      pend_reg_write <= 1'b0;
      pend_reg_addr  <= '0;
      pend_alu       <= '0;
    end else begin
      // Result and error are single-cycle pulses.
      wb_valid <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          // dm_ack here is late or spurious and is deliberately ignored.
          if (accept) begin
            if (trap) begin
              wb_valid     <= 1'b1;
              bus_err      <= 1'b1;
              wb_reg_write <= 1'b0;
              wb_reg_addr  <= write_reg_addr;
              wb_data      <= alu_out;
            end else if (is_mem) begin
              // mem_read & mem_write together resolve to a store.
              dm_req         <= 1'b1;
              dm_we          <= mem_write;
              dm_addr        <= {alu_out[31:2], 2'b00};
              dm_wdata       <= write_data;
              pend_reg_write <= reg_write & ~mem_write;
              pend_reg_addr  <= write_reg_addr;
              pend_alu       <= alu_out;
              wdog           <= '0;
              state          <= WAIT;
            end else begin
              wb_valid     <= 1'b1;
              wb_reg_write <= reg_write;
              wb_reg_addr  <= write_reg_addr;
              wb_data      <= alu_out;
            end
          end
        end
        WAIT: begin
          // Ack is tested first so an ack on the timeout edge completes.
          if (dm_ack) begin
            dm_req       <= 1'b0;
            state        <= IDLE;
            wdog         <= '0;
            wb_valid     <= 1'b1;
            wb_reg_write <= pend_reg_write;
            wb_reg_addr  <= pend_reg_addr;
            wb_data      <= dm_we ? pend_alu : dm_rdata;
          end else if (wdog == WDOG_LAST) begin
            dm_req       <= 1'b0;
            state        <= IDLE;
            wdog         <= '0;
            wb_valid     <= 1'b1;
            bus_err      <= 1'b1;
            wb_reg_write <= 1'b0;
            wb_reg_addr  <= pend_reg_addr;
            wb_data      <= pend_alu;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage. The bench plays data memory,
// predicts each WB result from a word-addressed memory model, and a
// negedge monitor pops and compares predictions whenever wb_valid fires.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [31:0] alu_out, write_data;
  logic [4:0]  write_reg_addr;
  logic        mem_read, mem_write, reg_write;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        wb_valid, wb_reg_write, bus_err;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_data;

  mem_access_stage #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_out(alu_out), .write_data(write_data), .write_reg_addr(write_reg_addr),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_reg_addr(wb_reg_addr), .wb_data(wb_data),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        rw;
    logic [4:0]  ra;
    logic [31:0] data;
    logic        chk_data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem[logic [29:0]];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [29:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return {2'b10, wa};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic err, input logic rw, input logic [4:0] ra,
                              input logic [31:0] d, input logic cd);
    exp_t e;
    e.err = err; e.rw = rw; e.ra = ra; e.data = d; e.chk_data = cd;
    return e;
  endfunction

  // Monitor: every WB pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_err) chk("bus_err_without_wb_valid", {31'b0, wb_valid}, 32'd1);
      if (wb_valid) begin
        if (q.size() == 0) begin
          chk("wb_valid_unexpected", {31'b0, wb_valid}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wb_bus_err", {31'b0, bus_err}, {31'b0, e.err});
          chk("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, e.rw});
          if (e.rw) chk("wb_reg_addr", {27'b0, wb_reg_addr}, {27'b0, e.ra});
          if (e.chk_data) chk("wb_data", wb_data, e.data);
        end
      end
    end
  end

  task automatic drive_idle();
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
  endtask

  // Issues one ALU op; caller decides whether to idle afterwards.
  task automatic issue_alu(input logic [31:0] a, input logic rw, input logic [4:0] ra);
    chk("ex_ready_alu", {31'b0, ex_ready}, 32'd1);
    ex_valid = 1'b1; alu_out = a; write_data = $urandom; write_reg_addr = ra;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = rw;
    q.push_back(mk(1'b0, rw, ra, a, 1'b1));
    tick();
  endtask

  // Issues a load/store and acts as memory: ack in the delay-th request
  // cycle, or never if delay exceeds the watchdog limit.
  task automatic issue_mem(input logic ld, input logic st, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] ra,
                           input logic rw, input int delay);
    logic [29:0] wa;
    logic        trapped;
    logic        store;
    logic [31:0] rd;
    wa = a[31:2];
    store = st;
    trapped = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trapped = (a[1:0] != 2'b00);
`endif
    chk("ex_ready_mem", {31'b0, ex_ready}, 32'd1);
    ex_valid = 1'b1; alu_out = a; write_data = wd; write_reg_addr = ra;
    mem_read = ld; mem_write = st; reg_write = rw;
    if (trapped) begin
      q.push_back(mk(1'b1, 1'b0, ra, 32'h0, 1'b0));
      tick();
      drive_idle();
      chk("trap_no_dm_req", {31'b0, dm_req}, 32'd0);
      chk("trap_ex_ready", {31'b0, ex_ready}, 32'd1);
      return;
    end
    tick();
    drive_idle();
    for (int c = 1; c <= TO; c++) begin
      chk("dm_req_held", {31'b0, dm_req}, 32'd1);
      chk("dm_addr", dm_addr, {wa, 2'b00});
      chk("dm_we", {31'b0, dm_we}, {31'b0, store});
      if (store) chk("dm_wdata", dm_wdata, wd);
      chk("ex_ready_wait", {31'b0, ex_ready}, 32'd0);
      if (c == delay) begin
        rd = mem_rd(wa);
        dm_ack = 1'b1;
        dm_rdata = store ? $urandom : rd;
        if (store) begin
          q.push_back(mk(1'b0, 1'b0, ra, 32'h0, 1'b0));
          mem[wa] = wd;
        end else begin
          q.push_back(mk(1'b0, rw, ra, rd, 1'b1));
        end
        tick();
        dm_ack = 1'b0;
        break;
      end
      if (c == TO) q.push_back(mk(1'b1, 1'b0, ra, 32'h0, 1'b0));
      tick();
    end
    chk("dm_req_dropped", {31'b0, dm_req}, 32'd0);
    chk("ex_ready_after", {31'b0, ex_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    alu_out = '0; write_data = '0; write_reg_addr = '0;
    drive_idle();
    tick(); tick();
    chk("rst_ex_ready", {31'b0, ex_ready}, 32'd1);
    chk("rst_dm_req", {31'b0, dm_req}, 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // ALU op, then three back-to-back.
    issue_alu(32'h0000_0010, 1'b1, 5'd5);
    drive_idle(); tick();
    issue_alu(32'h1111_0001, 1'b1, 5'd1);
    issue_alu(32'h2222_0002, 1'b0, 5'd2);
    issue_alu(32'h3333_0003, 1'b1, 5'd3);
    drive_idle(); tick();

    // Load acked in third request cycle.
    mem[30'h40] = 32'hDEAD_BEEF;
    issue_mem(1'b1, 1'b0, 32'h100, 32'h0, 5'd7, 1'b1, 3);
    // Store acked in first request cycle, then read it back.
    issue_mem(1'b0, 1'b1, 32'h204, 32'h1234_5678, 5'd9, 1'b1, 1);
    issue_mem(1'b1, 1'b0, 32'h204, 32'h0, 5'd10, 1'b1, 1);
    // Both mem_read and mem_write: treated as a store.
    issue_mem(1'b1, 1'b1, 32'h208, 32'hCAFE_0001, 5'd11, 1'b1, 2);
    // Ack on the timeout cycle completes normally.
    issue_mem(1'b1, 1'b0, 32'h208, 32'h0, 5'd12, 1'b1, TO);
    // Never acked: watchdog abort, then a late ack must be ignored.
    issue_mem(1'b1, 1'b0, 32'h300, 32'h0, 5'd13, 1'b1, 100);
    dm_ack = 1'b1; dm_rdata = 32'hBAD0_BAD0;
    tick();
    dm_ack = 1'b0;
    chk("late_ack_no_req", {31'b0, dm_req}, 32'd0);
    tick();

    // Reset during WAIT abandons the access silently.
    ex_valid = 1'b1; alu_out = 32'h400; mem_read = 1'b1; reg_write = 1'b1;
    write_reg_addr = 5'd14;
    tick();
    drive_idle();
    chk("pre_rst_dm_req", {31'b0, dm_req}, 32'd1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_dm_req", {31'b0, dm_req}, 32'd0);
    chk("mid_rst_ex_ready", {31'b0, ex_ready}, 32'd1);
    tick();
    issue_mem(1'b1, 1'b0, 32'h100, 32'h0, 5'd15, 1'b1, 2);

    // Misaligned load.
    issue_mem(1'b1, 1'b0, 32'h102, 32'h0, 5'd16, 1'b1, 1);
    drive_idle(); tick();

    // Randomized mix.
    for (int i = 0; i < 200; i++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = 32'h100 + ({28'b0, 4'($urandom_range(0, 15))} << 2);
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      case (kind)
        0: issue_alu($urandom, 1'($urandom), 5'($urandom));
        1: issue_mem(1'b1, 1'b0, a, 32'h0, 5'($urandom), 1'($urandom),
                     $urandom_range(1, TO + 2));
        2: issue_mem(1'b0, 1'b1, a, $urandom, 5'($urandom), 1'($urandom),
                     $urandom_range(1, TO + 2));
        default: issue_mem(1'b1, 1'b1, a, $urandom, 5'($urandom), 1'b1,
                           $urandom_range(1, TO));
      endcase
      drive_idle();
      if ($urandom_range(0, 2) == 0) begin
        dm_ack = 1'($urandom);
        dm_rdata = $urandom;
        tick();
        dm_ack = 1'b0;
      end
    end

    tick(); tick(); tick();
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
